// File: rtl/fpnew_result_fifo_if.sv
// Result handshake bundle between an opgroup block, the result FIFO and
// the FPU output arbiter. slave = FIFO side, master = environment side.
interface fpnew_result_fifo_if #(
    parameter int unsigned Width    = 32,
    parameter int unsigned TagWidth = 1
);
    // upstream (opgroup -> FIFO)
    logic [Width-1:0]    in_result_i;
    logic [4:0]          in_status_i;
    logic                in_ext_bit_i;
    logic [TagWidth-1:0] in_tag_i;
    logic                in_valid_i;
    logic                in_ready_o;
    // downstream (FIFO -> arbiter)
    logic [Width-1:0]    result_o;
    logic [4:0]          status_o;
    logic                extension_bit_o;
    logic [TagWidth-1:0] tag_o;
    logic                out_valid_o;
    logic                out_ready_i;

    modport slave (
        input  in_result_i, in_status_i, in_ext_bit_i, in_tag_i, in_valid_i,
        output in_ready_o,
        output result_o, status_o, extension_bit_o, tag_o, out_valid_o,
        input  out_ready_i
    );

    modport master (
        output in_result_i, in_status_i, in_ext_bit_i, in_tag_i, in_valid_i,
        input  in_ready_o,
        input  result_o, status_o, extension_bit_o, tag_o, out_valid_o,
        output out_ready_i
    );
endinterface

// File: rtl/fpnew_result_fifo.sv
// Output-side result FIFO behind an opgroup: buffers Depth entries in
// order and accumulates sticky IEEE flags from every popped entry.
//
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   io             fpnew_result_fifo_if.slave (in_* push side, out_* pop side)
//   flush_i        discard all buffered entries
//   fflags_clr_i   clear sticky flags (applies before a same-cycle pop)
//   fflags_o       sticky OR of popped status {NV,DZ,OF,UF,NX}
//   count_o        occupancy
//   busy_o         data held or arriving
//
// Option: define FPNEW_RESFIFO_FALLTHROUGH_EN for a zero-latency path
// when the FIFO is empty. Default build has strict 1-cycle latency.
module fpnew_result_fifo #(
    parameter  int unsigned Width    = 32,
    parameter  int unsigned TagWidth = 1,
    parameter  int unsigned Depth    = 4,
    localparam int unsigned CntW     = $clog2(Depth + 1),
    localparam int unsigned PtrW     = $clog2(Depth)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    fpnew_result_fifo_if.slave      io,
    input  logic                    flush_i,
    input  logic                    fflags_clr_i,
    output logic [4:0]              fflags_o,
    output logic [CntW-1:0]         count_o,
    output logic                    busy_o
);

    localparam logic [CntW-1:0] DEPTH_C = CntW'(Depth);
    localparam logic [PtrW-1:0] LAST_C  = PtrW'(Depth - 1);

    // storage (not reset)
    logic [Width-1:0]    r_result [Depth];
    logic [4:0]          r_status [Depth];
    logic                r_ext    [Depth];
    logic [TagWidth-1:0] r_tag    [Depth];

    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic [4:0]      r_fflags;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_store;
    logic            w_pop_mem;
    logic [4:0]      w_fflags_base;
    logic [4:0]      w_fflags_nxt;
    logic [PtrW-1:0] w_wptr_inc;
    logic [PtrW-1:0] w_rptr_inc;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    assign io.in_ready_o = ~w_full;

    // pointer increment with wrap at Depth-1 (Depth need not be 2^n)
    assign w_wptr_inc = (r_wptr == LAST_C) ? '0 : r_wptr + PtrW'(1);
    assign w_rptr_inc = (r_rptr == LAST_C) ? '0 : r_rptr + PtrW'(1);

`ifdef FPNEW_RESFIFO_FALLTHROUGH_EN
    logic w_ft;
    logic w_bypass;

    // empty FIFO forwards the incoming entry in the same cycle
    assign w_ft     = w_empty & io.in_valid_i & ~flush_i;
    assign w_bypass = w_ft & io.out_ready_i;

    assign io.out_valid_o = ~w_empty | w_ft;

    always_comb begin
        io.result_o        = '0;
        io.status_o        = '0;
        io.extension_bit_o = 1'b0;
        io.tag_o           = '0;
        if (w_ft) begin
            io.result_o        = io.in_result_i;
            io.status_o        = io.in_status_i;
            io.extension_bit_o = io.in_ext_bit_i;
            io.tag_o           = io.in_tag_i;
        end else if (!w_empty) begin
            io.result_o        = r_result[r_rptr];
            io.status_o        = r_status[r_rptr];
            io.extension_bit_o = r_ext[r_rptr];
            io.tag_o           = r_tag[r_rptr];
        end
    end

    // a bypassed entry is consumed without touching storage
    assign w_store   = io.in_valid_i & ~w_full & ~flush_i & ~w_bypass;
    assign w_pop_mem = w_pop & ~w_empty;
`else
    assign io.out_valid_o = ~w_empty;

    always_comb begin
        io.result_o        = '0;
        io.status_o        = '0;
        io.extension_bit_o = 1'b0;
        io.tag_o           = '0;
        if (!w_empty) begin
            io.result_o        = r_result[r_rptr];
            io.status_o        = r_status[r_rptr];
            io.extension_bit_o = r_ext[r_rptr];
            io.tag_o           = r_tag[r_rptr];
        end
    end

    assign w_store   = io.in_valid_i & ~w_full & ~flush_i;
    assign w_pop_mem = w_pop;
`endif

    // flush discards any same-cycle pop, so it never reaches fflags
    assign w_pop = io.out_valid_o & io.out_ready_i & ~flush_i;

    // clear first, then merge the status of the entry leaving this cycle
    assign w_fflags_base = fflags_clr_i ? 5'b0 : r_fflags;
    assign w_fflags_nxt  = w_fflags_base | (w_pop ? io.status_o : 5'b0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_count  <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_fflags <= '0;
        end else begin
            r_fflags <= w_fflags_nxt;
            if (flush_i) begin
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else begin
                if (w_store) begin
                    r_wptr <= w_wptr_inc;
                end
                if (w_pop_mem) begin
                    r_rptr <= w_rptr_inc;
                end
                unique case ({w_store, w_pop_mem})
                    2'b10:   r_count <= r_count + CntW'(1);
                    2'b01:   r_count <= r_count - CntW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && w_store) begin
            r_result[r_wptr] <= io.in_result_i;
            r_status[r_wptr] <= io.in_status_i;
            r_ext[r_wptr]    <= io.in_ext_bit_i;
            r_tag[r_wptr]    <= io.in_tag_i;
        end
    end

    assign fflags_o = r_fflags;
    assign count_o  = r_count;
    assign busy_o   = ~w_empty | io.in_valid_i;

endmodule

// File: tb/tb_fpnew_result_fifo.sv
// Scoreboard bench for fpnew_result_fifo: driver queues expected entries
// on acceptance, a monitor pops and compares on every output handshake.
module tb_fpnew_result_fifo;

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  s;
        logic        e;
        logic        t;
    } ent_t;

`ifdef FPNEW_RESFIFO_FALLTHROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       flush = 1'b0;
    logic       clr = 1'b0;
    logic [4:0] fflags;
    logic [2:0] count;
    logic       busy;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t exp_q[$];

    fpnew_result_fifo_if #(.Width(32), .TagWidth(1)) bus ();

    fpnew_result_fifo #(.Width(32), .TagWidth(1), .Depth(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .io           (bus),
        .flush_i      (flush),
        .fflags_clr_i (clr),
        .fflags_o     (fflags),
        .count_o      (count),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d entries pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: compares every output handshake with the scoreboard head
    always @(negedge clk) begin
        ent_t got;
        ent_t e;
        #1;
        if (rst_ni && bus.out_valid_o && bus.out_ready_i && !flush) begin
            got = '{bus.result_o, bus.status_o, bus.extension_bit_o, bus.tag_o};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got 0x%0h expected none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h", got, e);
                end
            end
        end
    end

    // drive one entry, hold until accepted (bounded), queue expectation
    task automatic push(input logic [31:0] r, input logic [4:0] s,
                        input logic e, input logic t);
        bit acc = 0;
        bus.in_result_i  = r;
        bus.in_status_i  = s;
        bus.in_ext_bit_i = e;
        bus.in_tag_i     = t;
        bus.in_valid_i   = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (bus.in_ready_o && !flush && rst_ni) begin
                exp_q.push_back('{r, s, e, t});
                acc = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid_i = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: got stalled expected accept 0x%0h", r);
        end
    endtask

    task automatic drain();
        int k = 0;
        bus.out_ready_i = 1'b1;
        while (k < 50 && (exp_q.size() != 0 || count != 0)) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_count", 32'(count), 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        bus.in_result_i  = '0;
        bus.in_status_i  = '0;
        bus.in_ext_bit_i = 1'b0;
        bus.in_tag_i     = 1'b0;
        bus.in_valid_i   = 1'b0;
        bus.out_ready_i  = 1'b0;

        // reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid_o), 0);
        check("rst_ready", 32'(bus.in_ready_o), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(count), 0);
        check("rst_fflags", 32'(fflags), 0);
        check("rst_result", bus.result_o, 0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // fill to full, stall a 5th, then drain in order
        for (int i = 1; i <= 4; i++)
            push(32'(i), 5'h0, 1'(i % 2), 1'(i - 1));
        check("full_count", 32'(count), 4);
        check("full_ready", 32'(bus.in_ready_o), 0);
        fork
            push(32'h5, 5'h0, 1'b1, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                check("stall_count", 32'(count), 4);
                check("stall_busy", 32'(busy), 1);
                bus.out_ready_i = 1'b1;
                @(posedge clk);
                #1;
                check("first_pop_count", 32'(count), 3);
                check("first_pop_ready", 32'(bus.in_ready_o), 1);
            end
        join
        drain();

        // steady push+pop every cycle, pointers wrap
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(32'h100 + 32'(i), 5'h0, 1'(i % 3 == 0), 1'(i % 2));
            check("steady_count", 32'(count), FT ? 0 : 1);
        end
        drain();

        // sticky flags
        bus.out_ready_i = 1'b0;
        push(32'h11, 5'h01, 1'b0, 1'b0);
        push(32'h12, 5'h10, 1'b1, 1'b1);
        push(32'h13, 5'h04, 1'b0, 1'b0);
        bus.out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        check("fflags_or", 32'(fflags), 32'h11);
        check("fflags_cnt", 32'(count), 1);
        clr = 1'b1;
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.out_ready_i = 1'b0;
        check("fflags_clr_pop", 32'(fflags), 32'h04);
        check("clr_pop_count", 32'(count), 0);

        // flush with concurrent push and pop
        for (int i = 0; i < 3; i++)
            push(32'h20 + 32'(i), 5'h02, 1'b0, 1'(i));
        check("preflush_count", 32'(count), 3);
        bus.in_result_i  = 32'hBAD;
        bus.in_status_i  = 5'h08;
        bus.in_valid_i   = 1'b1;
        bus.out_ready_i  = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        exp_q.delete();
        check("flush_count", 32'(count), 0);
        check("flush_valid", 32'(bus.out_valid_o), 0);
        check("flush_fflags", 32'(fflags), 32'h04);
        repeat (3) @(posedge clk);
        #1;

        // clear without pop
        bus.out_ready_i = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("fflags_clr", 32'(fflags), 0);

        // reset mid-operation, glitch first
        for (int i = 0; i < 3; i++)
            push(32'h30 + 32'(i), 5'h02, 1'b1, 1'(i));
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        check("prerst_count", 32'(count), 2);
        check("prerst_fflags", 32'(fflags), 32'h02);
        @(negedge clk);
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check("glitch_count", 32'(count), 2);
        check("glitch_fflags", 32'(fflags), 32'h02);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        exp_q.delete();
        check("mrst_count", 32'(count), 0);
        check("mrst_valid", 32'(bus.out_valid_o), 0);
        check("mrst_fflags", 32'(fflags), 0);
        check("mrst_ready", 32'(bus.in_ready_o), 1);

        // latency from an empty FIFO
        @(posedge clk);
        #1;
        bus.in_result_i  = 32'hDEAD;
        bus.in_status_i  = 5'h00;
        bus.in_ext_bit_i = 1'b1;
        bus.in_tag_i     = 1'b1;
        bus.in_valid_i   = 1'b1;
        bus.out_ready_i  = 1'b1;
        #1;
        check("lat_valid0", 32'(bus.out_valid_o), FT ? 1 : 0);
        check("lat_result0", bus.result_o, FT ? 32'hDEAD : 32'h0);
        @(negedge clk);
        if (bus.in_ready_o) exp_q.push_back('{32'hDEAD, 5'h0, 1'b1, 1'b1});
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        check("lat_count1", 32'(count), FT ? 0 : 1);
        check("lat_valid1", 32'(bus.out_valid_o), FT ? 0 : 1);
        check("lat_result1", bus.result_o, FT ? 32'h0 : 32'hDEAD);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpnew_result_fifo.md
Name: fpnew_result_fifo

Overview:
- Output-side buffer placed directly downstream of an opgroup block.
- Accepts result, status, extension bit and tag over a valid/ready handshake, and buffers up to Depth entries in order.
- Presents buffered entries to the FPU output arbiter, so a stalled consumer does not stall the opgroup pipeline.
- Accumulates sticky IEEE exception flags from every entry that is popped.

Parameters:
- Width, 32, result width in bits.
- TagWidth, 1, tag width in bits.
- Depth, 4, number of entries; must be at least 2. Need not be a power of two.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- in_result_i  in  Width  result from the opgroup.
- in_status_i  in  5  status flags, ordered {NV,DZ,OF,UF,NX}.
- in_ext_bit_i  in  1  extension bit.
- in_tag_i  in  TagWidth  operation tag.
- in_valid_i  in  1  upstream valid.
- in_ready_o  out  1  upstream ready.
- result_o  out  Width  head entry result.
- status_o  out  5  head entry status.
- extension_bit_o  out  1  head entry extension bit.
- tag_o  out  TagWidth  head entry tag.
- out_valid_o  out  1  downstream valid.
- out_ready_i  in  1  downstream ready.
- flush_i  in  1  discard all buffered entries.
- fflags_clr_i  in  1  clear the sticky flags.
- fflags_o  out  5  sticky OR of the status of every popped entry.
- count_o  out  $clog2(Depth+1)  current occupancy.
- busy_o  out  1  data held or arriving.

Behaviour:
- Reset: evaluated only on a clk_i edge with rst_ni=0.
  - Sets count=0, read and write pointers=0, fflags=0.
  - Reset values: out_valid_o=0, in_ready_o=1, busy_o=0, count_o=0, fflags_o=0.
  - result_o, status_o, extension_bit_o and tag_o are 0 while empty.
  - Reset asserted mid-operation discards all entries; storage contents are not cleared.
- Push: occurs when in_valid_i & in_ready_o. Data is written at wptr; wptr advances and wraps from Depth-1 to 0.
- Pop: occurs when out_valid_o & out_ready_i. rptr advances and wraps from Depth-1 to 0.
- in_ready_o = (count < Depth). It does not depend on out_ready_i; there is no push-through when full.
- out_valid_o = (count != 0). The data outputs are the storage entry at rptr, driven combinationally from the registers.
- Latency, base build: 1 cycle. An entry pushed in cycle N is visible at the output in cycle N+1.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Full (count=Depth): in_ready_o=0. An upstream in_valid_i is held, not lost.
- Empty: out_valid_o=0. out_ready_i is ignored.
- Handshake rules:
  - Once out_valid_o=1, the head data stays stable until it is popped or flushed.
  - Upstream must hold its data stable while in_valid_i=1 and in_ready_o=0.
- Flush (flush_i=1 at a clock edge):
  - Next state: count=0, rptr=wptr=0.
  - Any push or pop in the same cycle is discarded and does not update fflags.
  - fflags are not cleared by flush.
  - in_ready_o stays combinationally as computed during the flush cycle.
- Sticky flags:
  - On each pop, fflags <= fflags | status_o.
  - fflags_clr_i with no pop: fflags <= 0.
  - fflags_clr_i together with a pop: fflags <= status_o of the popped entry, i.e. the clear applies first.
- busy_o = (count != 0) | in_valid_i.
- Extension bit and tag are stored and returned unmodified; tag order equals push order.

Optional Feature:
- Macro: FPNEW_RESFIFO_FALLTHROUGH_EN.
- Defined, when count=0 and in_valid_i=1:
  - out_valid_o=1 and the outputs show the in_* values in the same cycle.
  - If out_ready_i=1 as well, the entry passes through without being stored, count stays 0, and fflags accumulate in_status_i.
  - If out_ready_i=0, the entry is stored normally.
  - flush_i=1 blocks the fall-through path: out_valid_o=0 that cycle.
- Not defined: strict 1-cycle latency as described under Behaviour; there is no combinational path from in_* to out_*.

Test Plan:
- Reset, then push 4 entries with results 0x1..0x4, tags 0,1,0,1 and out_ready_i=0.
  - After the 4th push: count_o=4, in_ready_o=0.
  - A 5th in_valid_i is stalled.
  - Then out_ready_i=1: results 0x1..0x4 are popped in order, and the 5th entry is accepted the cycle after the first pop.
- Steady push and pop every cycle for 20 cycles, Depth=4 → count_o stays 1, pointers wrap 5 times, no entry lost or duplicated.
- Pop statuses 0x01 (NX) and then 0x10 (NV) → fflags_o=0x11.
  - Pulse fflags_clr_i together with a pop of status 0x04 → fflags_o=0x04.
- With 3 entries held, assert flush_i in the same cycle as in_valid_i=1 and out_ready_i=1.
  - Next cycle: count_o=0, out_valid_o=0, fflags_o unchanged.
  - The pushed entry never appears at the output.
- Assert rst_ni=0 for one edge while 2 entries are held → count_o=0, out_valid_o=0, fflags_o=0.
  - Asynchronous glitches on rst_ni between edges have no effect.
- With FPNEW_RESFIFO_FALLTHROUGH_EN defined, empty FIFO, in_valid_i=1, result 0xDEAD, out_ready_i=1 → out_valid_o=1 and result_o=0xDEAD in the same cycle, count_o remains 0.
  - Without the macro, the same stimulus gives out_valid_o=1 one cycle later.
